inception_branch_sync_ctrl: RTL
===============================

Name: inception_branch_sync_ctrl

Overview:
- Sequencing controller for an Inception block with parallel conv/maxpool branches of unequal latency.
- Buffered branches park results in per-branch FIFOs; one unbuffered "lead" branch (longest latency) drives its result directly.
- This block tracks FIFO occupancy, issues the common aligned FIFO read, and frames one image (start → all outputs delivered → done).
- It also flags overflow/underflow of the branch buffers.

Parameters:
- NUM_BRANCH, 4, number of branches; one is the lead, the rest are buffered.
- LEAD, 2, index of the unbuffered lead branch.
- FIFO_DEPTH, 64, entries per branch FIFO.
- IN_PIXELS, 25, input pixels per frame (IMG_Width*IMG_Height).
- OUT_PIXELS, 25, output pixels per frame per branch.
- CNT_W, 16, width of the pixel counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a frame
- valid_in  in  1  input-pixel strobe fed to all branches
- br_valid  in  NUM_BRANCH  per-branch result strobe; bit LEAD comes from the lead branch
- read  out  1  common FIFO read strobe (combinational)
- valid_out  out  1  aligned concat-output valid, registered
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse at frame end
- err_ovf  out  1  sticky: write to a buffered branch at FIFO_DEPTH
- err_udf  out  1  sticky: lead valid while any buffered branch is empty

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; all occupancy and pixel counters go to 0.
  - read=0, valid_out=0, busy=0, frame_done=0, err_ovf=0, err_udf=0.
  - Reset mid-frame aborts the frame immediately; no frame_done pulse.
- States:
  - IDLE: start → RUN. valid_in and br_valid are ignored in IDLE.
  - RUN: counts valid_in into in_cnt. Moves to DRAIN on the edge where in_cnt reaches IN_PIXELS.
  - DRAIN: valid_in is ignored. Moves to DONE when out_cnt reaches OUT_PIXELS.
  - DONE: frame_done=1 for one cycle → IDLE.
  - If out_cnt reaches OUT_PIXELS while still in RUN, go straight to DONE.
  - start outside IDLE is ignored.
- Occupancy counter per buffered branch i (i≠LEAD), width clog2(FIFO_DEPTH+1):
  - occ_i <= occ_i + (br_valid[i] & busy) − read.
  - Write and read in the same cycle leaves occ_i unchanged.
- read:
  - read = busy & br_valid[LEAD] & (occ_i≥1 for every buffered i).
  - Same-cycle writes do not count; the FIFO needs a registered entry before it can be read.
- valid_out: registered copy of read (1-cycle latency), aligned with the FIFO registered data_out and the lead output register.
- out_cnt increments on each read.
- err_ovf:
  - Set when br_valid[i] & busy & occ_i==FIFO_DEPTH & !read.
  - occ_i saturates; the write is dropped.
- err_udf:
  - Set when busy & br_valid[LEAD] & some occ_i==0.
  - No read is issued, that lead pixel is lost, and out_cnt does not advance.
- Both error flags clear only on reset or on the next start.
- Counters clear on start. in_cnt and out_cnt saturate at their targets.

Optional Feature:
- Macro: INCEPTION_SYNC_PERF_EN.
- Defined:
  - Adds output lat_cycles [CNT_W-1:0], reset 0, cleared on start.
  - Counts cycles from start to the first read of the frame, then freezes.
  - Adds output max_occ [clog2(FIFO_DEPTH+1)-1:0]: high-water mark over all buffered occ_i, cleared on start.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Decomposition:
- Shared package inception_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the occupancy-width function/constant OCC_W = clog2(FIFO_DEPTH+1);
  - default DEPTH and pixel constants used by the Inception wrappers.
- One sub-module: branch_occ_counter (up/down counter with saturation and overflow flag), instantiated NUM_BRANCH−1 times by generate, skipping LEAD.

Test Plan:
- Nominal frame: start; 25 valid_in; branches 0,1,3 each pulse 25 times before lead branch 2 pulses 25 times → 25 read pulses, 25 valid_out each 1 cycle after read, frame_done 1 cycle after the 25th read, busy low afterwards, no errors.
- Same-cycle write/read: occ_1=1, br_valid[1] and lead valid in the same cycle → read=1, occ_1 stays 1.
- Underflow: branch 3 never pulses, lead pulses once → read=0, err_udf=1 next cycle, out_cnt stays 0.
- Overflow: 65 br_valid[0] pulses with no lead pulse → occ_0=64, err_ovf=1 on the 65th.
- Reset mid-DRAIN: rst=0 for 1 cycle → state IDLE, all outputs 0, no frame_done; a new start runs a clean frame.
- PERF build: lead's first pulse 40 cycles after start with the buffers filled → lat_cycles=40; max_occ equals the peak injected occupancy.

Source files
------------

// File: rtl/inception_pkg.sv
// -----------------------------------------------------------------------------
// inception_pkg
// Shared definitions for the Inception branch-synchronisation logic.
//   - state_t       : frame sequencing states (IDLE, RUN, DRAIN, DONE)
//   - occ_width()   : bits needed to hold an occupancy of 0..depth inclusive
//   - DEF_*         : default FIFO depth and pixel counts used by the wrappers
//   - OCC_W         : occupancy width for the default FIFO depth
// -----------------------------------------------------------------------------
package inception_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_FIFO_DEPTH = 64;
    localparam int DEF_IN_PIXELS  = 25;
    localparam int DEF_OUT_PIXELS = 25;

    // An occupancy counter must represent "full" (== depth), hence depth+1.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int OCC_W = occ_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/branch_occ_counter.sv
// -----------------------------------------------------------------------------
// branch_occ_counter
// Occupancy tracker for one buffered branch FIFO. Counts writes up and reads
// down, saturates at DEPTH (the write is dropped) and reports an overflow
// attempt combinationally so the parent can latch a sticky flag.
// Ports:
//   clk, rst (sync, active-low)
//   clr  : clear occupancy (frame start)
//   wr   : branch result written this cycle
//   rd   : common aligned read this cycle
//   occ  : registered occupancy
//   ovf  : write attempted while full with no read to make room
// -----------------------------------------------------------------------------
module branch_occ_counter #(
    parameter int DEPTH = 64,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    output logic [W-1:0] occ,
    output logic         ovf
);

    logic [W-1:0] occ_reg;
    logic [W-1:0] occ_next;
    logic         full;

    assign full = (occ_reg == W'(DEPTH));
    // A read in the same cycle frees a slot, so write+read at full is legal.
    assign ovf  = wr & full & ~rd;
    assign occ  = occ_reg;

    always_comb begin
        occ_next = occ_reg;
        if (clr) begin
            occ_next = '0;
        end else if (wr && !rd && !full) begin
            occ_next = occ_reg + W'(1);
        end else if (rd && !wr && (occ_reg != '0)) begin
            occ_next = occ_reg - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

endmodule

// File: rtl/inception_branch_sync_ctrl.sv
// -----------------------------------------------------------------------------
// inception_branch_sync_ctrl
// Sequencing controller for an Inception block whose parallel branches have
// unequal latency. Buffered branches park results in FIFOs; the lead branch
// (longest latency) drives its output directly. This block tracks FIFO
// occupancy, issues the common aligned read, frames one image and flags
// buffer overflow / underflow.
// Ports:
//   clk, rst (sync, active-low)
//   start      : one-cycle pulse, begins a frame (honoured in IDLE only)
//   valid_in   : input pixel strobe
//   br_valid   : per-branch result strobe, bit LEAD from the lead branch
//   read       : common FIFO read (combinational)
//   valid_out  : aligned output valid, one cycle after read
//   busy       : high in RUN or DRAIN
//   frame_done : one-cycle pulse at frame end
//   err_ovf    : sticky, write to a full buffered branch
//   err_udf    : sticky, lead valid while a buffered branch is empty
// Optional build macro INCEPTION_SYNC_PERF_EN adds:
//   lat_cycles : cycles from start to first read of the frame
//   max_occ    : high-water mark over all buffered occupancies
// -----------------------------------------------------------------------------
module inception_branch_sync_ctrl
    import inception_pkg::*;
#(
    parameter int NUM_BRANCH = 4,
    parameter int LEAD       = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int IN_PIXELS  = 25,
    parameter int OUT_PIXELS = 25,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_in,
    input  logic [NUM_BRANCH-1:0] br_valid,
    output logic                  read,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_ovf,
    output logic                  err_udf
`ifdef INCEPTION_SYNC_PERF_EN
    ,
    output logic [CNT_W-1:0]                  lat_cycles,
    output logic [occ_width(FIFO_DEPTH)-1:0]  max_occ
`endif
);

    localparam int OW = occ_width(FIFO_DEPTH);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] in_cnt_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic             valid_out_reg;
    logic             err_ovf_reg;
    logic             err_udf_reg;

    logic                  start_acc;
    logic [NUM_BRANCH-1:0] ne_vec;
    logic [NUM_BRANCH-1:0] ovf_vec;
    logic [OW-1:0]         occ_arr [NUM_BRANCH];
    logic                  all_ne;
    logic                  lead_v;
    logic                  in_hit;
    logic                  out_hit;

    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign start_acc = start && (state_reg == IDLE);

    // One occupancy counter per buffered branch; the lead slot is tied to a
    // constant "always has data" value so the read AND-reduction stays uniform.
    generate
        for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_branch
            if (gi == LEAD) begin : g_lead
                assign occ_arr[gi] = '0;
                assign ne_vec[gi]  = 1'b1;
                assign ovf_vec[gi] = 1'b0;
            end else begin : g_buf
                branch_occ_counter #(
                    .DEPTH (FIFO_DEPTH),
                    .W     (OW)
                ) u_occ (
                    .clk (clk),
                    .rst (rst),
                    .clr (start_acc),
                    .wr  (br_valid[gi] & busy),
                    .rd  (read),
                    .occ (occ_arr[gi]),
                    .ovf (ovf_vec[gi])
                );
                // Registered occupancy only: a same-cycle write is not yet readable.
                assign ne_vec[gi] = (occ_arr[gi] != '0);
            end
        end
    endgenerate

    assign all_ne = &ne_vec;
    assign lead_v = br_valid[LEAD];
    assign read   = busy & lead_v & all_ne;

    assign in_hit  = (state_reg == RUN) && valid_in && (in_cnt_reg == CNT_W'(IN_PIXELS - 1));
    assign out_hit = read && (out_cnt_reg == CNT_W'(OUT_PIXELS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = RUN;
            // All outputs may already be delivered before the input finishes.
            RUN: begin
                if (out_hit)     state_next = DONE;
                else if (in_hit) state_next = DRAIN;
            end
            DRAIN: if (out_hit) state_next = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- counters, flags, output valid ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            valid_out_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
            err_udf_reg   <= 1'b0;
        end else begin
            valid_out_reg <= read;
            if (start_acc) begin
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                err_ovf_reg <= 1'b0;
                err_udf_reg <= 1'b0;
            end else begin
                if ((state_reg == RUN) && valid_in && (in_cnt_reg < CNT_W'(IN_PIXELS))) begin
                    in_cnt_reg <= in_cnt_reg + CNT_W'(1);
                end
                if (read && (out_cnt_reg < CNT_W'(OUT_PIXELS))) begin
                    out_cnt_reg <= out_cnt_reg + CNT_W'(1);
                end
                if (|ovf_vec) begin
                    err_ovf_reg <= 1'b1;
                end
                // Lead pixel arrives with a buffered branch empty: it is lost.
                if (busy && lead_v && !all_ne) begin
                    err_udf_reg <= 1'b1;
                end
            end
        end
    end

    assign valid_out = valid_out_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_udf   = err_udf_reg;

`ifdef INCEPTION_SYNC_PERF_EN
    logic [CNT_W-1:0] lat_reg;
    logic             lat_run_reg;
    logic [OW-1:0]    max_reg;
    logic [OW-1:0]    peak_now;

    always_comb begin
        peak_now = '0;
        for (int i = 0; i < NUM_BRANCH; i++) begin
            if (occ_arr[i] > peak_now) peak_now = occ_arr[i];
        end
    end

    // The cycle carrying the first read is included in the latency count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_reg     <= '0;
            lat_run_reg <= 1'b0;
            max_reg     <= '0;
        end else if (start_acc) begin
            lat_reg     <= '0;
            lat_run_reg <= 1'b1;
            max_reg     <= '0;
        end else begin
            if (lat_run_reg && busy) begin
                if (lat_reg != '1) lat_reg <= lat_reg + CNT_W'(1);
                if (read) lat_run_reg <= 1'b0;
            end
            if (peak_now > max_reg) max_reg <= peak_now;
        end
    end

    assign lat_cycles = lat_reg;
    assign max_occ    = max_reg;
`endif

endmodule
